pwm_nch: RTL and testbench
==========================

PWM_NCH -- requirements
Module: pwm_nch

Interface
REQ-001 Parameter NCH, default 4, number of independent PWM channels (1..8).
REQ-002 Parameter CW, default 16, counter/period/duty width in bits (2..32).
REQ-003 clk_i  in  1  sole clock; every flop is on its rising edge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 re_i  in  1  register read strobe.
REQ-006 we_i  in  1  register write strobe; a write occurs only when we_i=1 and re_i=0.
REQ-007 addr_i  in  8  byte address.
REQ-008 wdata_i  in  32  write data.
REQ-009 be_i  in  4  byte enables; only enabled bytes are written.
REQ-010 rdata_o  out  32  read data, combinational from addr_i; zero-extended; 0 for unmapped addresses.
REQ-011 error_o  out  1  combinational; 1 when re_i or we_i is set and addr_i is unmapped or addr_i[1:0]!=0.
REQ-012 i_dc  in  NCH*CW  external duty per channel; channel n uses slice [n*CW +: CW].
REQ-013 i_valid_dc  in  NCH  per-channel strobe that captures the i_dc slice into ext_dc[n].
REQ-014 pwm_o  out  NCH  registered PWM outputs.
REQ-015 irq_o  out  1  OR over (irq_status & irq_en).

Function
REQ-016 Channel n registers sit at base n*0x10: CTRL +0x0, DIV +0x4, PERIOD +0x8, DUTY +0xC; IRQ_STATUS at 0x80 and IRQ_EN at 0x84 use bits [NCH-1:0]. All other addresses are unmapped; writes to them are ignored and error_o=1.
REQ-017 CTRL bits: 0 EN; 1 OE; 2 POL (invert output); 3 CENTER (up/down mode); 4 ONESHOT; 5 EXTDC (use ext_dc[n] as duty); 6 CLR (write-1 pulse, always reads 0). Bits 31:7 read as 0.
REQ-018 Prescaler: while EN=1, the per-channel prescaler asserts a tick once every DIV+1 clk_i cycles, so DIV=0 gives a tick on every cycle. The prescaler count is held at 0 while EN=0.
REQ-019 PERIOD and DUTY writes go to shadow registers and read back as shadow values. Active copies load from shadow at each period end, and on every cycle while EN=0.
REQ-020 Edge mode (CENTER=0): on each tick the counter goes 0,1,..,P-1 and then wraps to 0. Period end is the tick on which the counter wraps.
REQ-021 Center mode (CENTER=1): on each tick the counter goes 0 up to P-1 and then P-1 down to 0, with each endpoint held for two ticks. One period is 2P ticks. Period end is the tick that leaves cnt=0 while counting down.
REQ-022 On each tick, pts[n] <= (cnt < D), where D is ext_dc[n] if EXTDC=1, else the active DUTY.
 - D=0 gives constant 0.
 - D>=P gives constant 1.
REQ-023 P=0: counter held at 0 and pts=0; no period ends occur.
REQ-024 pwm_o[n] = OE ? (pts[n] XOR POL) : 0, driven from a flop. pwm_o changes one clk_i cycle after the tick.
REQ-025 Each period end sets irq_status[n]; a set event wins over a simultaneous W1C clear.
REQ-026 Writing 1 to a bit of IRQ_STATUS clears that bit (W1C).
REQ-027 ONESHOT=1: at the first period end, hardware clears EN, so the counter and pts go to 0. If a software write to CTRL occurs in the same cycle, the software write wins.
REQ-028 EN=0 or CLR=1 forces cnt, count direction, prescaler and pts to 0 on the next edge. CLR=1 also clears irq_status[n] and ext_dc[n]. CLR takes precedence over i_valid_dc in the same cycle.
REQ-029 Arithmetic is unsigned CW-bit; the counter never exceeds P-1, and PERIOD = 2^CW-1 operates without overflow.
REQ-030 Channels are fully independent, sharing only the bus and irq_o.

Reset
REQ-031 rst_i=1 at a clock edge zeroes every register:
 - CTRL, DIV, shadow and active PERIOD/DUTY;
 - ext_dc, counters, prescalers;
 - irq_status, irq_en.
REQ-032 During and after reset: pwm_o=0 and irq_o=0; rdata_o reads 0 for all mapped registers.
REQ-033 Reset asserted mid-period overrides all bus writes and i_valid_dc in the same cycle.

Verification
REQ-034 Channel 0: DIV=0, PERIOD=10, DUTY=3, CTRL=EN|OE -> pwm_o[0] high 3 of every 10 cycles; irq_status[0] set every 10 cycles.
REQ-035 Channel 1: DIV=1, PERIOD=4, DUTY=2, CTRL=EN|OE|CENTER -> period of 16 clk_i cycles; pwm_o[1] high for 8 contiguous cycles, centred on the cnt=0 turnaround.
REQ-036 Edge mode, PERIOD=8, DUTY=2: write DUTY=6 mid-period -> the current period keeps 2-tick high; the next period is 6-tick high.
REQ-037 CTRL=EN|OE|POL|ONESHOT, PERIOD=5, DUTY=5 with IRQ_EN[0]=1:
 - pwm_o[0] low for 5 ticks, then high;
 - EN reads 0 after the period end;
 - irq_o=1 until 1 is written to IRQ_STATUS bit 0.
REQ-038 EXTDC=1 with i_valid_dc[2]=1 and i_dc slice=7, PERIOD=10 -> channel 2 high 7 of 10 ticks. Write to address 0x90 -> error_o=1 and no register changes.
REQ-039 rst_i pulsed mid-period on a running channel -> next cycle: pwm_o=0, all registers read 0, irq_o=0.

Source files
------------

// File: rtl/pwm_nch.sv
// Multi-channel PWM block: per-channel prescaler, edge/center counting, shadowed
// period/duty, external duty capture and a shared W1C interrupt status/enable pair.

module pwm_nch_ch #(
  parameter int CW = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [3:0]    i_wr_sel,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_be,
  input  logic [1:0]    i_rsel,
  output logic [31:0]   o_rdata,
  input  logic [CW-1:0] i_dc,
  input  logic          i_valid_dc,
  input  logic          i_irq_clr,
  output logic          o_irq,
  output logic          o_pwm
);
  localparam int EN = 0, OE = 1, POL = 2, CTR = 3, ONE = 4, EXT = 5;

  logic [5:0]    r_ctrl;
  logic [CW-1:0] r_div, r_per_sh, r_duty_sh, r_per, r_duty, r_ext, r_psc, r_cnt;
  logic          r_down, r_pts, r_pwm, r_irq;

  logic [31:0]   w_mask, w_ctrl_m, w_div_m, w_per_m, w_duty_m;
  logic [CW-1:0] w_d, w_pm1, w_cnt_nxt;
  logic          w_en, w_clr, w_tick, w_pe, w_down_nxt, w_pts_nxt;

  assign w_mask   = {{8{i_be[3]}}, {8{i_be[2]}}, {8{i_be[1]}}, {8{i_be[0]}}};
  assign w_ctrl_m = (32'(r_ctrl)    & ~w_mask) | (i_wdata & w_mask);
  assign w_div_m  = (32'(r_div)     & ~w_mask) | (i_wdata & w_mask);
  assign w_per_m  = (32'(r_per_sh)  & ~w_mask) | (i_wdata & w_mask);
  assign w_duty_m = (32'(r_duty_sh) & ~w_mask) | (i_wdata & w_mask);

  assign w_en   = r_ctrl[EN];
  assign w_clr  = i_wr_sel[0] & w_ctrl_m[6];
  // >= so a DIV lowered below the running prescale count still ticks promptly
  assign w_tick = w_en && (r_psc >= r_div);
  assign w_d    = r_ctrl[EXT] ? r_ext : r_duty;
  assign w_pm1  = r_per - CW'(1);

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_down_nxt = r_down;
    w_pts_nxt  = r_pts;
    w_pe       = 1'b0;
    if (!w_en || w_clr) begin
      w_cnt_nxt  = '0;
      w_down_nxt = 1'b0;
      w_pts_nxt  = 1'b0;
    end else if (w_tick) begin
      if (r_per == '0) begin
        w_cnt_nxt  = '0;
        w_down_nxt = 1'b0;
        w_pts_nxt  = 1'b0;
      end else begin
        w_pts_nxt = (r_cnt < w_d);
        if (!r_ctrl[CTR]) begin
          w_down_nxt = 1'b0;
          if (r_cnt >= w_pm1) begin
            w_cnt_nxt = '0;
            w_pe      = 1'b1;
          end else w_cnt_nxt = r_cnt + CW'(1);
        end else if (!r_down) begin
          // top endpoint is held for a second tick by turning without moving
          if (r_cnt >= w_pm1) begin
            w_cnt_nxt  = w_pm1;
            w_down_nxt = 1'b1;
          end else w_cnt_nxt = r_cnt + CW'(1);
        end else begin
          if (r_cnt == '0) begin
            w_down_nxt = 1'b0;
            w_pe       = 1'b1;
          end else w_cnt_nxt = r_cnt - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl <= '0; r_div <= '0; r_per_sh <= '0; r_duty_sh <= '0;
      r_per <= '0; r_duty <= '0; r_ext <= '0; r_psc <= '0; r_cnt <= '0;
      r_down <= 1'b0; r_pts <= 1'b0; r_pwm <= 1'b0; r_irq <= 1'b0;
    end else begin
      if (i_wr_sel[0])                r_ctrl     <= w_ctrl_m[5:0];
      else if (w_pe && r_ctrl[ONE])   r_ctrl[EN] <= 1'b0;
      if (i_wr_sel[1]) r_div     <= w_div_m[CW-1:0];
      if (i_wr_sel[2]) r_per_sh  <= w_per_m[CW-1:0];
      if (i_wr_sel[3]) r_duty_sh <= w_duty_m[CW-1:0];
      if (!w_en || w_pe) begin
        r_per  <= r_per_sh;
        r_duty <= r_duty_sh;
      end
      r_psc <= (!w_en || w_clr || w_tick) ? '0 : r_psc + CW'(1);
      if (w_clr)           r_ext <= '0;
      else if (i_valid_dc) r_ext <= i_dc;
      if (w_pe)                      r_irq <= 1'b1;
      else if (w_clr || i_irq_clr)   r_irq <= 1'b0;
      r_cnt  <= w_cnt_nxt;
      r_down <= w_down_nxt;
      r_pts  <= w_pts_nxt;
      r_pwm  <= r_ctrl[OE] ? (w_pts_nxt ^ r_ctrl[POL]) : 1'b0;
    end
  end

  always_comb begin
    case (i_rsel)
      2'd0:    o_rdata = 32'(r_ctrl);
      2'd1:    o_rdata = 32'(r_div);
      2'd2:    o_rdata = 32'(r_per_sh);
      default: o_rdata = 32'(r_duty_sh);
    endcase
  end

  assign o_irq = r_irq;
  assign o_pwm = r_pwm;
endmodule

module pwm_nch #(
  parameter int NCH = 4,
  parameter int CW  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              re_i,
  input  logic              we_i,
  input  logic [7:0]        addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [3:0]        be_i,
  output logic [31:0]       rdata_o,
  output logic              error_o,
  input  logic [NCH*CW-1:0] i_dc,
  input  logic [NCH-1:0]    i_valid_dc,
  output logic [NCH-1:0]    pwm_o,
  output logic              irq_o
);
  logic                  w_ch_hit, w_is_st, w_is_en, w_map, w_wr;
  logic [NCH-1:0]        w_irq, w_w1c, r_irq_en;
  logic [NCH-1:0][31:0]  w_rd;

  assign w_ch_hit = (addr_i[7:4] < 4'(NCH));
  assign w_is_st  = (addr_i == 8'h80);
  assign w_is_en  = (addr_i == 8'h84);
  assign w_map    = (addr_i[1:0] == 2'b00) && (w_ch_hit || w_is_st || w_is_en);
  assign w_wr     = we_i && !re_i && w_map;
  assign error_o  = (re_i || we_i) && !w_map;
  assign w_w1c    = (w_wr && w_is_st && be_i[0]) ? wdata_i[NCH-1:0] : '0;

  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic [3:0] w_sel;
    assign w_sel = (w_wr && w_ch_hit && addr_i[7:4] == 4'(n)) ? (4'b0001 << addr_i[3:2]) : 4'b0000;
    pwm_nch_ch #(.CW(CW)) u_ch (
      .clk_i(clk_i), .rst_i(rst_i), .i_wr_sel(w_sel), .i_wdata(wdata_i), .i_be(be_i),
      .i_rsel(addr_i[3:2]), .o_rdata(w_rd[n]), .i_dc(i_dc[n*CW +: CW]),
      .i_valid_dc(i_valid_dc[n]), .i_irq_clr(w_w1c[n]), .o_irq(w_irq[n]), .o_pwm(pwm_o[n])
    );
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)                          r_irq_en <= '0;
    else if (w_wr && w_is_en && be_i[0]) r_irq_en <= wdata_i[NCH-1:0];
  end

  always_comb begin
    rdata_o = '0;
    if (w_map) begin
      if (w_is_st)      rdata_o = 32'(w_irq);
      else if (w_is_en) rdata_o = 32'(r_irq_en);
      else for (int n = 0; n < NCH; n++) if (addr_i[7:4] == 4'(n)) rdata_o = w_rd[n];
    end
  end

  assign irq_o = |(w_irq & r_irq_en);
endmodule

// File: tb/tb_pwm_nch.sv
// Bench for pwm_nch: directed scenarios plus random bus/duty traffic, checked
// every cycle against a phase-counting reference model.
module tb_pwm_nch;
  localparam int NCH = 4, CW = 16;
  localparam int unsigned MSK = 32'hFFFF_FFFF >> (32 - CW);

  logic clk = 1'b0, rst, re, we, err, irq;
  logic [7:0] addr;
  logic [31:0] wdata, rdata;
  logic [3:0] be;
  logic [NCH*CW-1:0] dc;
  logic [NCH-1:0] vdc, pwm;

  always #5 clk = ~clk;

  pwm_nch #(.NCH(NCH), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst), .re_i(re), .we_i(we), .addr_i(addr), .wdata_i(wdata),
    .be_i(be), .rdata_o(rdata), .error_o(err), .i_dc(dc), .i_valid_dc(vdc),
    .pwm_o(pwm), .irq_o(irq)
  );

  // model: ph is the tick index inside the current period
  int unsigned m_ctrl[NCH], m_div[NCH], m_psh[NCH], m_dsh[NCH], m_pa[NCH], m_da[NCH];
  int unsigned m_ext[NCH], m_psc[NCH], m_ph[NCH], m_ien;
  bit m_pts[NCH], m_pwm[NCH], m_irq[NCH];
  int nvec = 0, nerr = 0;

  function automatic bit mapped(logic [7:0] a);
    return (a[1:0] == 2'b00) && ((int'(a) < NCH*16) || a == 8'h80 || a == 8'h84);
  endfunction

  function automatic int unsigned merge(int unsigned old);
    int unsigned r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wdata[8*i +: 8];
    return r;
  endfunction

  function automatic int unsigned irq_bits();
    int unsigned r = 0;
    for (int n = 0; n < NCH; n++) r[n] = m_irq[n];
    return r;
  endfunction

  function automatic int unsigned mrd(logic [7:0] a);
    int ch, r;
    if (!mapped(a)) return 0;
    if (a == 8'h80) return irq_bits();
    if (a == 8'h84) return m_ien;
    ch = int'(a) / 16; r = (int'(a) % 16) / 4;
    case (r)
      0: return m_ctrl[ch];
      1: return m_div[ch];
      2: return m_psh[ch];
      default: return m_dsh[ch];
    endcase
  endfunction

  function automatic int unsigned m_pwmv();
    int unsigned r = 0;
    for (int n = 0; n < NCH; n++) r[n] = m_pwm[n];
    return r;
  endfunction

  function automatic void model_update();
    int a; bit wr; int unsigned w1c;
    a  = int'(addr);
    wr = we && !re && mapped(addr);
    if (rst) begin
      for (int n = 0; n < NCH; n++) begin
        m_ctrl[n] = 0; m_div[n] = 0; m_psh[n] = 0; m_dsh[n] = 0; m_pa[n] = 0; m_da[n] = 0;
        m_ext[n] = 0; m_psc[n] = 0; m_ph[n] = 0; m_pts[n] = 0; m_pwm[n] = 0; m_irq[n] = 0;
      end
      m_ien = 0;
      return;
    end
    w1c = (wr && a == 'h80 && be[0]) ? 32'(wdata[NCH-1:0]) : 0;
    for (int n = 0; n < NCH; n++) begin
      bit chw, en, clr, tick, pe, npts;
      int r;
      int unsigned P, D, L, nph, cnt;
      chw  = wr && a < NCH*16 && (a / 16) == n;
      r    = (a % 16) / 4;
      en   = m_ctrl[n][0];
      clr  = chw && r == 0 && be[0] && wdata[6];
      tick = en && m_psc[n] >= m_div[n];
      P = m_pa[n];
      D = m_ctrl[n][5] ? m_ext[n] : m_da[n];
      L = m_ctrl[n][3] ? 2*P : P;
      pe = 0; npts = m_pts[n]; nph = m_ph[n];
      if (!en || clr) begin
        nph = 0; npts = 0;
      end else if (tick) begin
        if (P == 0) begin
          nph = 0; npts = 0;
        end else begin
          cnt  = (!m_ctrl[n][3] || m_ph[n] < P) ? m_ph[n] : 2*P - 1 - m_ph[n];
          npts = (cnt < D);
          nph  = m_ph[n] + 1;
          if (nph == L) begin nph = 0; pe = 1; end
        end
      end
      m_pwm[n] = m_ctrl[n][1] ? (npts ^ m_ctrl[n][2]) : 1'b0;
      m_psc[n] = (!en || clr || tick) ? 0 : m_psc[n] + 1;
      m_pts[n] = npts; m_ph[n] = nph;
      if (!en || pe) begin m_pa[n] = m_psh[n]; m_da[n] = m_dsh[n]; end
      if (pe) m_irq[n] = 1; else if (clr || w1c[n]) m_irq[n] = 0;
      if (clr) m_ext[n] = 0; else if (vdc[n]) m_ext[n] = 32'(dc[n*CW +: CW]);
      if (chw && r == 0) m_ctrl[n] = merge(m_ctrl[n]) & 'h3f;
      else if (pe && m_ctrl[n][4]) m_ctrl[n][0] = 1'b0;
      if (chw && r == 1) m_div[n] = merge(m_div[n]) & MSK;
      if (chw && r == 2) m_psh[n] = merge(m_psh[n]) & MSK;
      if (chw && r == 3) m_dsh[n] = merge(m_dsh[n]) & MSK;
    end
    if (wr && a == 'h84 && be[0]) m_ien = 32'(wdata[NCH-1:0]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    chk("rdata_o", rdata, mrd(addr));
    chk("error_o", 32'(err), 32'((re || we) && !mapped(addr)));
    @(posedge clk);
    model_update();
    #1;
    chk("pwm_o", 32'(pwm), m_pwmv());
    chk("irq_o", 32'(irq), 32'(|(irq_bits() & m_ien)));
  endtask

  task automatic idle();
    we = 0; re = 0; vdc = '0; be = 4'hF;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    addr = a; wdata = d; be = 4'hF; we = 1; re = 0;
    cyc();
    idle();
  endtask

  task automatic run(input int n, input int ch, output int hi, output int rises);
    logic prev;
    hi = 0; rises = 0; prev = pwm[ch];
    repeat (n) begin
      cyc();
      if (pwm[ch]) hi++;
      if (pwm[ch] && !prev) rises++;
      prev = pwm[ch];
    end
  endtask

  task automatic read_all(input bit expect_zero);
    logic [7:0] a;
    for (int i = 0; i < NCH*4 + 2; i++) begin
      a = (i < NCH*4) ? 8'(i*4) : ((i == NCH*4) ? 8'h80 : 8'h84);
      addr = a; re = 1; we = 0;
      #1;
      if (expect_zero) chk("read_zero", rdata, 32'd0);
      cyc();
    end
    idle();
  endtask

  int hi, rises;

  initial begin
    rst = 1; idle(); addr = 0; wdata = 0; dc = '0;
    repeat (2) @(posedge clk);
    model_update();
    #1;
    cyc();
    chk("rst_pwm", 32'(pwm), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    read_all(1);
    rst = 0;
    cyc();

    // ch0 edge mode: 3 of 10 cycles high
    wr(8'h04, 0); wr(8'h08, 10); wr(8'h0C, 3); wr(8'h84, 1); wr(8'h00, 32'h03);
    run(5, 0, hi, rises);
    run(10, 0, hi, rises);
    chk("ch0_edge_high", 32'(hi), 32'd3);

    // ch1 center mode: 16-cycle period, 8 contiguous high
    wr(8'h14, 1); wr(8'h18, 4); wr(8'h1C, 2); wr(8'h10, 32'h0B);
    run(6, 1, hi, rises);
    run(16, 1, hi, rises);
    chk("ch1_center_high", 32'(hi), 32'd8);
    chk("ch1_center_rises", 32'(rises), 32'd1);

    // ch3 duty change mid-period takes effect next period
    wr(8'h38, 8); wr(8'h3C, 2); wr(8'h30, 32'h03);
    run(3, 3, hi, rises);
    wr(8'h3C, 6);
    run(12, 3, hi, rises);
    chk("ch3_shadow_duty", 32'(hi), 32'd6);

    // ch0 oneshot with inverted polarity
    wr(8'h00, 32'h40); wr(8'h08, 5); wr(8'h0C, 5); wr(8'h00, 32'h17);
    run(10, 0, hi, rises);
    chk("oneshot_low", 32'(10 - hi), 32'd5);
    chk("oneshot_pwm_after", 32'(pwm[0]), 32'd1);
    addr = 8'h00; re = 1; #1;
    chk("oneshot_en_clear", 32'(rdata[0]), 32'd0);
    chk("oneshot_irq_held", 32'(irq), 32'd1);
    cyc(); idle();
    wr(8'h80, 1);
    chk("oneshot_irq_w1c", 32'(irq), 32'd0);

    // ch2 external duty
    dc[2*CW +: CW] = 16'd7; vdc = 4'b0100; cyc(); idle();
    wr(8'h28, 10); wr(8'h20, 32'h23);
    run(5, 2, hi, rises);
    run(10, 2, hi, rises);
    chk("ch2_extdc_high", 32'(hi), 32'd7);
    addr = 8'h90; wdata = 32'hFFFF_FFFF; we = 1; #1;
    chk("unmapped_err", 32'(err), 32'd1);
    cyc(); idle();
    read_all(0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      idle();
      case ($urandom_range(0, 9))
        0, 1, 2: we = 1;
        3:       re = 1;
        4:       begin re = 1; we = 1; end
        default: ;
      endcase
      case ($urandom_range(0, 7))
        0:       addr = 8'($urandom);
        1:       addr = ($urandom_range(0, 1) == 0) ? 8'h80 : 8'h84;
        default: addr = {2'b00, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'b00};
      endcase
      wdata = $urandom_range(0, 11);
      if ($urandom_range(0, 15) == 0) wdata = $urandom;
      be = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      // mode bits only change together with CLR so counting restarts cleanly
      if (addr < 8'h40 && addr[3:2] == 2'd0) begin
        wdata = $urandom_range(0, 63) | 32'h40; be = 4'hF;
      end
      for (int n = 0; n < NCH; n++) dc[n*CW +: CW] = CW'($urandom_range(0, 12));
      vdc = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      cyc();
    end
    idle();

    // reset mid-period overrides a simultaneous write and duty strobe
    wr(8'h84, 32'hF); wr(8'h08, 10); wr(8'h0C, 3); wr(8'h00, 32'h43);
    run(7, 0, hi, rises);
    rst = 1; we = 1; addr = 8'h0C; wdata = 9; vdc = '1;
    cyc();
    rst = 0; idle();
    chk("rst_mid_pwm", 32'(pwm), 32'd0);
    chk("rst_mid_irq", 32'(irq), 32'd0);
    read_all(1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
